run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side run sequencer upstream of the 8-bit, 9-bit-instruction processor top level. It preloads data memory from a byte stream, holds the core in reset, then releases it and counts cycles until the core raises `Done` or a watchdog expires. It finally streams a window of data memory back out. While the core is not running, the sequencer owns the data-memory port, which the top level muxes using `mem_sel`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: cycles `core_reset` stays asserted after the last preload byte.
- `TIMEOUT_CYCLES`, default 1000: watchdog limit in RUN cycles; must be less than 2^16.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a run; honoured only in IDLE or DONE.
- `dump_len` in 9: number of bytes to dump, 0..256; sampled on an accepted `start`.
- `load_valid`, `load_last` in 1: preload stream valid and last-byte flag.
- `load_data` in 8: preload byte.
- `load_ready` out 1: sequencer accepts a preload byte.
- `dm_wen` out 1: data-memory write enable.
- `dm_addr` out 8: data-memory address.
- `dm_wdata` out 8: data-memory write data.
- `dm_rdata` in 8: data-memory combinational read data.
- `mem_sel` out 1: 1 means the sequencer drives the DM port; 0 means the core drives it.
- `core_reset` out 1: active-high reset to the core.
- `core_done` in 1: the core's `Done`.
- `out_valid` out 1: dump stream valid.
- `out_data` out 8: dump byte.
- `out_ready` in 1: dump sink ready.
- `busy`, `finished`, `timed_out` out 1: status flags.
- `cycle_count` out 16: RUN cycles of the last run.

## Operation
- States:
  - IDLE → LOAD on `start`.
  - LOAD → HOLD on an accepted byte with `load_last` set.
  - HOLD → RUN after `HOLD_CYCLES` cycles.
  - RUN → DUMP on `core_done` or timeout.
  - DUMP → DONE after `dump_len` handshakes; DUMP → DONE immediately if `dump_len` = 0.
  - DONE → LOAD on `start`.
- Accepting `start`:
  - clears `finished`, `timed_out` and `cycle_count`;
  - resets the load address to 0;
  - latches `dump_len`.
- LOAD:
  - `load_ready` = 1.
  - A byte is accepted when `load_valid` and `load_ready` are both 1.
  - On acceptance, in the same cycle: `dm_wen` = 1, `dm_addr` = load address, `dm_wdata` = `load_data`.
  - The load address increments on each acceptance and wraps 255 → 0; later bytes overwrite earlier ones.
- `core_reset` = 1 in every state except RUN. `mem_sel` = 0 only in RUN.
- RUN:
  - `cycle_count` increments every cycle, including the cycle in which `core_done` is sampled high.
  - `cycle_count` freezes on leaving RUN.
- DUMP:
  - `dm_addr` = dump address.
  - `out_valid` = 1 and `out_data` = `dm_rdata`.
  - The dump address increments on `out_valid` && `out_ready`.
  - `out_data` = 0 whenever `out_valid` = 0.
- `busy` = 1 in LOAD, HOLD, RUN and DUMP. `finished` = 1 in DONE.
- `start` is ignored in LOAD, HOLD, RUN and DUMP. `load_valid` is ignored outside LOAD.
- `core_done` is ignored outside RUN, including a `Done` still high from a previous run.

## Timing
- Reset values:
  - state IDLE;
  - `core_reset` = 1, `mem_sel` = 1;
  - all other outputs 0, including `dm_addr` and `cycle_count`.
- Reset asserted mid-run aborts immediately to reset values; nothing further is written to DM.
- `start` accepted in cycle t: `load_ready` = 1 from t+1.
- RUN begins exactly `HOLD_CYCLES` cycles after the cycle in which the last byte is accepted.
- `core_done` high in the Nth RUN cycle:
  - `cycle_count` = N;
  - state is DUMP in the next cycle;
  - `mem_sel` returns to 1 in that same next cycle.
- Dump latency: the first `out_valid` is in the first DUMP cycle. Throughput is one byte per cycle while `out_ready` = 1.
- `out_data` holds its value while `out_valid` = 1 and `out_ready` = 0.
- `cycle_count` saturates at 0xFFFF and never wraps.

## Configuration
- `RUN_WATCHDOG_EN` defined:
  - when `cycle_count` reaches `TIMEOUT_CYCLES` without `core_done`, the next state is DUMP with `timed_out` = 1;
  - if `core_done` arrives in that same cycle, done wins and `timed_out` stays 0.
- `RUN_WATCHDOG_EN` undefined: RUN waits indefinitely and `timed_out` is tied to 0.

## Structure
- Shared package `run_seq_pkg` contains:
  - the state enum (IDLE, LOAD, HOLD, RUN, DUMP, DONE);
  - the `CYCLE_W` = 16 constant;
  - the default `HOLD_CYCLES` and `TIMEOUT_CYCLES`.
- One sub-module, `run_cycle_counter`: a saturating 16-bit counter with clear, enable and a terminal-compare output used by the watchdog.

## Test plan
- Load and run: start with `dump_len` = 3; load bytes 0x11, 0x22, 0x33 (last on 0x33). Expect:
  - DM writes at addresses 0–2 with those bytes;
  - `core_reset` high for exactly 2 cycles after the last byte;
  - `mem_sel` = 0 in RUN.
- Done timing: `core_done` in the 5th RUN cycle → `cycle_count` = 5, then the dump yields 0x11, 0x22, 0x33 and `finished` = 1.
- Back-pressure: during the dump, hold `out_ready` low for 3 cycles → `out_data` stable throughout and no byte is skipped or duplicated.
- Watchdog: with `RUN_WATCHDOG_EN`, `TIMEOUT_CYCLES` = 10 and no `core_done` → `timed_out` = 1 and `cycle_count` = 10. The same stimulus without the macro → still in RUN after 1000 cycles.
- Wrap: load 257 bytes, the last being 0xAB → address 0 holds 0xAB and address 1 holds the original 2nd byte.
- Async reset: assert `reset` low in mid-DUMP → `out_valid` = 0, `core_reset` = 1 and IDLE immediately, without waiting for a clock edge; a `start` in DONE restarts cleanly with cleared flags.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer slice.
package run_seq_pkg;

   localparam int unsigned CYCLE_W            = 16;
   localparam int unsigned HOLD_CYCLES_DEF    = 2;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HOLD,
      RUN,
      DUMP,
      DONE
   } seq_state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter with clear/enable and a terminal flag that
// fires in the cycle whose increment brings the count up to LIMIT.
module run_cycle_counter
   import run_seq_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   output logic [CYCLE_W-1:0] count,
   output logic               term
);

   localparam logic [CYCLE_W-1:0] TERM_AT = CYCLE_W'(LIMIT - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   // Compare against LIMIT-1 so the registered count equals LIMIT on exit.
   assign term = enable && (count == TERM_AT);

endmodule

// File: rtl/run_sequencer.sv
// Host-side preload / run / dump sequencer for the processor core.
// Optional watchdog: define RUN_WATCHDOG_EN to time out RUN after TIMEOUT_CYCLES.
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [8:0]         dump_len,
   input  logic               load_valid,
   input  logic               load_last,
   input  logic [7:0]         load_data,
   output logic               load_ready,
   output logic               dm_wen,
   output logic [7:0]         dm_addr,
   output logic [7:0]         dm_wdata,
   input  logic [7:0]         dm_rdata,
   output logic               mem_sel,
   output logic               core_reset,
   input  logic               core_done,
   output logic               out_valid,
   output logic [7:0]         out_data,
   input  logic               out_ready,
   output logic               busy,
   output logic               finished,
   output logic               timed_out,
   output logic [CYCLE_W-1:0] cycle_count
);

`ifdef RUN_WATCHDOG_EN
   localparam logic WD_EN = 1'b1;
`else
   localparam logic WD_EN = 1'b0;
`endif

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

   seq_state_t  state, state_next;
   logic [7:0]  load_addr;
   logic [7:0]  dump_addr;
   logic [8:0]  dump_left;
   logic [15:0] hold_cnt;
   logic        timed_out_r;
   logic        cnt_term;
   logic        wd_hit;
   logic        start_ok;
   logic        load_acc;
   logic        dump_hs;
   logic        timeout_now;

   assign start_ok    = start && ((state == IDLE) || (state == DONE));
   assign load_acc    = (state == LOAD) && load_valid;
   assign dump_hs     = out_valid && out_ready;
   assign wd_hit      = cnt_term & WD_EN;
   assign timeout_now = (state == RUN) && wd_hit && !core_done;

   run_cycle_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (start_ok),
      .enable (state == RUN),
      .count  (cycle_count),
      .term   (cnt_term)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_addr   <= '0;
         dump_addr   <= '0;
         dump_left   <= '0;
         hold_cnt    <= '0;
         timed_out_r <= 1'b0;
      end else begin
         if (start_ok) begin
            load_addr   <= '0;
            dump_addr   <= '0;
            dump_left   <= dump_len;
            timed_out_r <= 1'b0;
         end else begin
            if (load_acc) begin
               load_addr <= load_addr + 1'b1;
            end
            if (dump_hs) begin
               dump_addr <= dump_addr + 1'b1;
               dump_left <= dump_left - 1'b1;
            end
            if (timeout_now) begin
               timed_out_r <= 1'b1;
            end
         end
         hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_next = state;
      load_ready = 1'b0;
      dm_wen     = 1'b0;
      dm_addr    = '0;
      dm_wdata   = '0;
      mem_sel    = 1'b1;
      core_reset = 1'b1;
      out_valid  = 1'b0;
      out_data   = '0;
      case (state)
         IDLE, DONE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            load_ready = 1'b1;
            dm_addr    = load_addr;
            if (load_valid) begin
               dm_wen   = 1'b1;
               dm_wdata = load_data;
               if (load_last) state_next = (HOLD_CYCLES == 0) ? RUN : HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt == HOLD_LAST) state_next = RUN;
         end
         RUN: begin
            mem_sel    = 1'b0;
            core_reset = 1'b0;
            if (core_done || wd_hit) state_next = DUMP;
         end
         DUMP: begin
            dm_addr = dump_addr;
            // A zero-length dump spends one idle cycle here before DONE.
            if (dump_left != '0) begin
               out_valid = 1'b1;
               out_data  = dm_rdata;
               if (out_ready && (dump_left == 9'd1)) state_next = DONE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy      = (state == LOAD) || (state == HOLD) || (state == RUN) || (state == DUMP);
   assign finished  = (state == DONE);
   assign timed_out = timed_out_r;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer with a behavioural data memory.
module tb_run_sequencer;

`ifdef RUN_WATCHDOG_EN
   localparam int unsigned TMO = 10;
`else
   localparam int unsigned TMO = 1000;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic [8:0]  dump_len;
   logic        load_valid;
   logic        load_last;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        dm_wen;
   logic [7:0]  dm_addr;
   logic [7:0]  dm_wdata;
   logic [7:0]  dm_rdata;
   logic        mem_sel;
   logic        core_reset;
   logic        core_done;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        busy;
   logic        finished;
   logic        timed_out;
   logic [15:0] cycle_count;

   logic [7:0]  mem [256];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   run_sequencer #(
      .HOLD_CYCLES    (2),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dump_len    (dump_len),
      .load_valid  (load_valid),
      .load_last   (load_last),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .dm_wen      (dm_wen),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .mem_sel     (mem_sel),
      .core_reset  (core_reset),
      .core_done   (core_done),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .busy        (busy),
      .finished    (finished),
      .timed_out   (timed_out),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dm_wen && mem_sel) mem[dm_addr] <= dm_wdata;
   end
   assign dm_rdata = mem[dm_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last, input logic [7:0] a, input bit chk);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      #1;
      if (chk) begin
         check("ld_wen", dm_wen, 1'b1);
         check("ld_addr", dm_addr, a);
         check("ld_wdata", dm_wdata, d);
      end
   endtask

   // Two HOLD cycles with core held in reset, then arrive at the first RUN cycle.
   task automatic hold_to_run();
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
      check("hold1_crst", core_reset, 1'b1);
      check("hold1_rdy", load_ready, 1'b0);
      @(negedge clk); #1;
      check("hold2_crst", core_reset, 1'b1);
      check("hold2_msel", mem_sel, 1'b1);
      @(negedge clk); #1;
      check("run1_crst", core_reset, 1'b0);
      check("run1_msel", mem_sel, 1'b0);
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      dump_len   = '0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_data  = '0;
      core_done  = 1'b0;
      out_ready  = 1'b0;

      @(negedge clk); #1;
      check("rst_crst", core_reset, 1'b1);
      check("rst_msel", mem_sel, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_addr", dm_addr, 8'h00);
      check("rst_cnt", cycle_count, 16'd0);
      check("rst_oval", out_valid, 1'b0);

      @(negedge clk);
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'hEE;
      #1;
      check("idle_ign_load", dm_wen, 1'b0);
      load_valid = 1'b0;

      // Load and run
      @(negedge clk);
      start    = 1'b1;
      dump_len = 9'd3;
      #1;
      check("start_rdy_t", load_ready, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("start_rdy_t1", load_ready, 1'b1);
      check("load_busy", busy, 1'b1);
      load_byte(8'h11, 1'b0, 8'd0, 1'b1);
      load_byte(8'h22, 1'b0, 8'd1, 1'b1);
      load_byte(8'h33, 1'b1, 8'd2, 1'b1);
      hold_to_run();
      check("mem0", mem[0], 8'h11);
      check("mem2", mem[2], 8'h33);

      // Done in the 5th RUN cycle, then dump with back-pressure
      repeat (4) @(negedge clk);
      core_done = 1'b1;
      out_ready = 1'b1;
      #1;
      check("run5_cnt", cycle_count, 16'd4);
      check("run5_msel", mem_sel, 1'b0);
      @(negedge clk); #1;
      check("d1_msel", mem_sel, 1'b1);
      check("d1_cnt", cycle_count, 16'd5);
      check("d1_oval", out_valid, 1'b1);
      check("d1_data", out_data, 8'h11);
      @(negedge clk);
      core_done = 1'b0;
      out_ready = 1'b0;
      #1;
      check("bp1_data", out_data, 8'h22);
      @(negedge clk); #1;
      check("bp2_data", out_data, 8'h22);
      @(negedge clk); #1;
      check("bp3_data", out_data, 8'h22);
      check("bp3_oval", out_valid, 1'b1);
      out_ready = 1'b1;
      @(negedge clk); #1;
      check("d_data3", out_data, 8'h33);
      @(negedge clk); #1;
      check("done_fin", finished, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_oval", out_valid, 1'b0);
      check("done_odata", out_data, 8'h00);
      check("done_cnt", cycle_count, 16'd5);

      // Watchdog / long run with zero-length dump
      @(negedge clk);
      start    = 1'b1;
      dump_len = 9'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("rs_fin", finished, 1'b0);
      check("rs_cnt", cycle_count, 16'd0);
      load_byte(8'h5A, 1'b1, 8'd0, 1'b1);
      hold_to_run();
`ifdef RUN_WATCHDOG_EN
      repeat (9) @(negedge clk);
      #1;
      check("wd_pre_msel", mem_sel, 1'b0);
      check("wd_pre_to", timed_out, 1'b0);
      @(negedge clk); #1;
      check("wd_to", timed_out, 1'b1);
      check("wd_cnt", cycle_count, 16'd10);
      check("wd_msel", mem_sel, 1'b1);
      check("wd_oval", out_valid, 1'b0);
`else
      repeat (1000) @(negedge clk);
      #1;
      check("long_msel", mem_sel, 1'b0);
      check("long_busy", busy, 1'b1);
      check("long_cnt", cycle_count, 16'd1000);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      #1;
      check("long_msel2", mem_sel, 1'b1);
      check("long_cnt2", cycle_count, 16'd1001);
      check("long_oval", out_valid, 1'b0);
      check("long_to", timed_out, 1'b0);
`endif
      @(negedge clk); #1;
      check("z_fin", finished, 1'b1);

      // Wrap: 257 bytes, last is 0xAB
      @(negedge clk);
      start    = 1'b1;
      dump_len = 9'd2;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("wr_fin", finished, 1'b0);
      check("wr_to", timed_out, 1'b0);
      for (int i = 0; i < 257; i++) begin
         if (i == 256) load_byte(8'hAB, 1'b1, 8'd0, 1'b1);
         else load_byte(8'(i + 1), 1'b0, 8'(i), (i < 2) || (i >= 254));
      end
      hold_to_run();
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      out_ready = 1'b1;
      #1;
      check("wr_mem0", mem[0], 8'hAB);
      check("wr_mem1", mem[1], 8'h02);
      check("wr_cnt", cycle_count, 16'd1);
      check("wr_d1", out_data, 8'hAB);
      @(negedge clk); #1;
      check("wr_d2", out_data, 8'h02);

      // Async reset mid-DUMP, away from any clock edge
      #2;
      reset = 1'b0;
      #1;
      check("ar_oval", out_valid, 1'b0);
      check("ar_crst", core_reset, 1'b1);
      check("ar_msel", mem_sel, 1'b1);
      check("ar_busy", busy, 1'b0);
      check("ar_addr", dm_addr, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      start    = 1'b1;
      dump_len = 9'd1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("ar_rs_rdy", load_ready, 1'b1);
      check("ar_rs_addr", dm_addr, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
